// File: rtl/scalar_proc_if.sv
// scalar_proc_if: instruction-in / writeback-observation bundle for scalar_proc.
//   inst_f  : instruction presented to fetch (driven by the trace source)
//   pc      : fetch PC
//   wb_en   : writeback valid this cycle
//   wb_reg  : destination register being written
//   wb_data : value being written
//   err     : sticky illegal-opcode flag
// master = trace source / bench side, slave = core side.
interface scalar_proc_if #(
  parameter int unsigned DW = 36
);
  logic [31:0]   inst_f;
  logic [DW-1:0] pc;
  logic          wb_en;
  logic [4:0]    wb_reg;
  logic [DW-1:0] wb_data;
  logic          err;

  modport master (
    output inst_f,
    input  pc, wb_en, wb_reg, wb_data, err
  );

  modport slave (
    input  inst_f,
    output pc, wb_en, wb_reg, wb_data, err
  );
endinterface

// File: rtl/scalar_proc.sv
// scalar_proc: 5-stage (F, D, E, M, W) in-order scalar pipeline, 36-bit datapath,
// 32-bit instructions, no branches, no memory function. Full forwarding, no stalls.
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : scalar_proc_if.slave (inst_f in; pc, wb_en, wb_reg, wb_data, err out)
module scalar_proc #(
  parameter int unsigned DW   = 36,
  parameter int unsigned NREG = 32
) (
  input  logic           clk,
  input  logic           rst,
  scalar_proc_if.slave   bus
);

  typedef enum logic [6:0] {
    OP_NOP  = 7'h00,
    OP_LIL  = 7'h01,
    OP_LIH  = 7'h02,
    OP_ADD  = 7'h03,
    OP_SUB  = 7'h04,
    OP_AND  = 7'h05,
    OP_OR   = 7'h06,
    OP_XOR  = 7'h07,
    OP_SHL  = 7'h08,
    OP_SHR  = 7'h09,
    OP_ADDI = 7'h0A
  } op_e;

  // Architectural state
  logic [DW-1:0] regs [NREG];
  logic [DW-1:0] pc_q;
  logic          err_q;

  // F/D
  logic [31:0]   fd_inst;

  // D/E
  logic [6:0]    de_op;
  logic [4:0]    de_rd;
  logic [17:0]   de_imm;
  logic [DW-1:0] de_a;
  logic [DW-1:0] de_b;

  // E/M
  logic          em_wr;
  logic [4:0]    em_rd;
  logic [DW-1:0] em_data;

  // M/W
  logic          mw_wr;
  logic [4:0]    mw_rd;
  logic [DW-1:0] mw_data;

  // Decode
  logic [6:0]    d_op;
  logic [4:0]    d_rd, d_ra, d_rb, d_src_a;
  logic          d_illegal;
  logic [DW-1:0] d_a, d_b;

  // Execute
  logic          e_wr;
  logic [DW-1:0] e_res;

  assign d_op      = fd_inst[31:25];
  assign d_rd      = fd_inst[24:20];
  assign d_ra      = fd_inst[19:15];
  assign d_rb      = fd_inst[14:10];
  assign d_illegal = (d_op > OP_ADDI);
  // LIL/LIH merge into the old rD value, so rD takes the first operand slot.
  assign d_src_a   = (d_op == OP_LIL || d_op == OP_LIH) ? d_rd : d_ra;

  // Operand forwarding: youngest producer wins (E > M > W > register file).
  // The W leg also makes the register file behave write-through.
  always_comb begin
    d_a = regs[d_src_a];
    if (e_wr && de_rd == d_src_a)       d_a = e_res;
    else if (em_wr && em_rd == d_src_a) d_a = em_data;
    else if (mw_wr && mw_rd == d_src_a) d_a = mw_data;

    d_b = regs[d_rb];
    if (e_wr && de_rd == d_rb)          d_b = e_res;
    else if (em_wr && em_rd == d_rb)    d_b = em_data;
    else if (mw_wr && mw_rd == d_rb)    d_b = mw_data;
  end

  // ALU
  always_comb begin
    e_res = '0;
    e_wr  = 1'b1;
    case (de_op)
      OP_LIL:  e_res = {de_a[DW-1:18], de_imm};
      OP_LIH:  e_res = {de_imm, de_a[17:0]};
      OP_ADD:  e_res = de_a + de_b;
      OP_SUB:  e_res = de_a - de_b;
      OP_AND:  e_res = de_a & de_b;
      OP_OR:   e_res = de_a | de_b;
      OP_XOR:  e_res = de_a ^ de_b;
      OP_SHL:  e_res = de_a << de_b[5:0];
      OP_SHR:  e_res = de_a >> de_b[5:0];
      OP_ADDI: e_res = de_a + {{(DW-15){de_imm[14]}}, de_imm[14:0]};
      default: e_wr  = 1'b0;
    endcase
  end

  // Pipeline registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      err_q   <= 1'b0;
      fd_inst <= '0;
      de_op   <= OP_NOP;
      de_rd   <= '0;
      de_imm  <= '0;
      de_a    <= '0;
      de_b    <= '0;
      em_wr   <= 1'b0;
      em_rd   <= '0;
      em_data <= '0;
      mw_wr   <= 1'b0;
      mw_rd   <= '0;
      mw_data <= '0;
    end else begin
      pc_q    <= pc_q + DW'(1);
      fd_inst <= bus.inst_f;

      de_op   <= d_op;
      de_rd   <= d_rd;
      de_imm  <= fd_inst[17:0];
      de_a    <= d_a;
      de_b    <= d_b;
      if (d_illegal) err_q <= 1'b1;

      em_wr   <= e_wr;
      em_rd   <= de_rd;
      em_data <= e_res;

      // wb_reg/wb_data only move on a real write so they hold across bubbles.
      mw_wr   <= em_wr;
      if (em_wr) begin
        mw_rd   <= em_rd;
        mw_data <= em_data;
      end
    end
  end

  // Register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (mw_wr) begin
      regs[mw_rd] <= mw_data;
    end
  end

  assign bus.pc      = pc_q;
  assign bus.wb_en   = mw_wr;
  assign bus.wb_reg  = mw_rd;
  assign bus.wb_data = mw_data;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_scalar_proc.sv
// tb_scalar_proc: self-checking bench for scalar_proc. An in-order architectural
// model executes each sampled instruction immediately and delays its writeback
// by three edges; a compare process checks every output on each falling edge.
module tb_scalar_proc;
  localparam int unsigned DW = 36;

  logic clk = 1'b0;
  logic rst;

  scalar_proc_if #(.DW(DW)) bus ();

  scalar_proc #(.DW(DW), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [35:0] d;
  } wb_t;

  int n_cmp;
  int n_fail;

  // Model state
  logic [35:0] m_regs [32];
  wb_t         m_pipe [$];
  logic        m_pend_ill;
  logic        exp_en;
  logic [4:0]  exp_reg;
  logic [35:0] exp_data;
  logic [35:0] exp_pc;
  logic        exp_err;

  // Directed program buffers
  logic [31:0] p_ins [$];
  bit          p_chk [$];
  logic [4:0]  p_reg [$];
  logic [35:0] p_val [$];

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [4:0] rb);
    return {op, rd, ra, rb, 10'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [4:0] ra, input logic [14:0] imm);
    return {op, rd, ra, imm};
  endfunction

  function automatic logic [31:0] enc_l(input logic [6:0] op, input logic [4:0] rd,
                                        input logic [17:0] imm);
    return {op, rd, 2'b00, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_pipe.delete();
    m_pend_ill = 1'b0;
    exp_en = 1'b0;
    exp_reg = '0;
    exp_data = '0;
    exp_pc = '0;
    exp_err = 1'b0;
  endtask

  // Architectural execution of one instruction in program order.
  function automatic wb_t model_exec(input logic [31:0] inst);
    wb_t         w;
    logic [6:0]  op;
    logic [4:0]  rd, ra, rb;
    logic [35:0] a, b, old, imm, r;
    int          sh;
    op  = inst[31:25];
    rd  = inst[24:20];
    ra  = inst[19:15];
    rb  = inst[14:10];
    a   = m_regs[ra];
    b   = m_regs[rb];
    old = m_regs[rd];
    sh  = int'(b % 64);
    imm = inst[14] ? (36'(inst[14:0]) - 36'h8000) : 36'(inst[14:0]);
    w.en = 1'b1;
    r = '0;
    case (op)
      7'h01: r = (old & 36'hFFFFC0000) | 36'(inst[17:0]);
      7'h02: r = (36'(inst[17:0]) * 36'h40000) | (old & 36'h00003FFFF);
      7'h03: r = a + b;
      7'h04: r = a - b;
      7'h05: r = a & b;
      7'h06: r = a | b;
      7'h07: r = a ^ b;
      7'h08: r = (sh >= 36) ? 36'd0 : (a << sh);
      7'h09: r = (sh >= 36) ? 36'd0 : (a >> sh);
      7'h0A: r = a + imm;
      default: w.en = 1'b0;
    endcase
    w.rd = rd;
    w.d  = r;
    if (w.en) m_regs[rd] = r;
    return w;
  endfunction

  // Model process: tracks reset, sampling edges and writeback delay.
  initial begin
    wb_t w;
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (rst !== 1'b1) begin
        model_reset();
      end else begin
        exp_pc = exp_pc + 36'd1;
        if (m_pend_ill) exp_err = 1'b1;
        m_pend_ill = (bus.inst_f[31:25] > 7'h0A);
        m_pipe.push_back(model_exec(bus.inst_f));
        if (m_pipe.size() > 3) begin
          w = m_pipe.pop_front();
          exp_en = w.en;
          if (w.en) begin
            exp_reg  = w.rd;
            exp_data = w.d;
          end
        end
      end
    end
  end

  // Compare process
  initial begin
    forever begin
      @(negedge clk);
      check("pc",      bus.pc,               exp_pc);
      check("wb_en",   36'(bus.wb_en),       36'(exp_en));
      check("wb_reg",  36'(bus.wb_reg),      36'(exp_reg));
      check("wb_data", bus.wb_data,          exp_data);
      check("err",     36'(bus.err),         36'(exp_err));
    end
  end

  task automatic issue(input logic [31:0] i);
    bus.inst_f = i;
    @(posedge clk);
    #2;
  endtask

  task automatic add(input logic [31:0] i, input bit chk, input logic [4:0] rg, input logic [35:0] v);
    p_ins.push_back(i);
    p_chk.push_back(chk);
    p_reg.push_back(rg);
    p_val.push_back(v);
  endtask

  // Issues the buffered program back-to-back, then checks each flagged
  // instruction's writeback on the cycle it reaches W (three edges later).
  task automatic run_prog(input string tag);
    int unsigned n;
    n = p_ins.size();
    for (int unsigned i = 0; i < n + 3; i++) begin
      issue(i < n ? p_ins[i] : 32'h0);
      if (i >= 3 && p_chk[i-3]) begin
        check({tag, "_en"},   36'(bus.wb_en),  36'd1);
        check({tag, "_reg"},  36'(bus.wb_reg), 36'(p_reg[i-3]));
        check({tag, "_data"}, bus.wb_data,     p_val[i-3]);
      end
    end
    p_ins.delete();
    p_chk.delete();
    p_reg.delete();
    p_val.delete();
  endtask

  task automatic pulse_reset();
    #1 rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    logic [31:0] ins;
    logic [6:0]  op;
    n_cmp = 0;
    n_fail = 0;
    bus.inst_f = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_pc",      bus.pc,              36'd0);
    check("rst_wb_en",   36'(bus.wb_en),      36'd0);
    check("rst_wb_reg",  36'(bus.wb_reg),     36'd0);
    check("rst_wb_data", bus.wb_data,         36'd0);
    check("rst_err",     36'(bus.err),        36'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // ADDI r1,r0,5
    issue(32'h14100005);
    repeat (3) issue(32'h0);
    check("addi_en",   36'(bus.wb_en),  36'd1);
    check("addi_reg",  36'(bus.wb_reg), 36'd1);
    check("addi_data", bus.wb_data,     36'h000000005);
    check("addi_err",  36'(bus.err),    36'd0);

    // LIH then LIL on r2, back-to-back
    add(enc_l(7'h02, 5'd2, 18'h3FFFF), 1, 5'd2, 36'hFFFFC0000);
    add(enc_l(7'h01, 5'd2, 18'h00001), 1, 5'd2, 36'hFFFFC0001);
    run_prog("lihlil");

    // ADD/SUB/XOR with wrap
    add(enc_i(7'h0A, 5'd1, 5'd0, 15'd7),     1, 5'd1, 36'h000000007);
    add(enc_i(7'h0A, 5'd3, 5'd0, 15'h7FFF),  1, 5'd3, 36'hFFFFFFFFF);
    add(enc_r(7'h03, 5'd4, 5'd1, 5'd3),      1, 5'd4, 36'h000000006);
    add(enc_r(7'h04, 5'd5, 5'd1, 5'd3),      1, 5'd5, 36'h000000008);
    add(enc_r(7'h07, 5'd6, 5'd1, 5'd3),      1, 5'd6, 36'hFFFFFFFF8);
    run_prog("alu");

    // Shifts, including a count >= 36
    add(enc_l(7'h02, 5'd1, 18'h20000),       1, 5'd1,  36'h800000007);
    add(enc_l(7'h01, 5'd1, 18'h00001),       1, 5'd1,  36'h800000001);
    add(enc_i(7'h0A, 5'd7, 5'd0, 15'd4),     1, 5'd7,  36'h000000004);
    add(enc_r(7'h08, 5'd8, 5'd1, 5'd7),      1, 5'd8,  36'h000000010);
    add(enc_r(7'h09, 5'd9, 5'd1, 5'd7),      1, 5'd9,  36'h080000000);
    add(enc_i(7'h0A, 5'd7, 5'd0, 15'd40),    1, 5'd7,  36'h000000028);
    add(enc_r(7'h08, 5'd10, 5'd1, 5'd7),     1, 5'd10, 36'h000000000);
    run_prog("shift");

    // Illegal opcode: sticky err, no writeback
    issue(32'hFE000000);
    issue(32'h0);
    check("ill_err", 36'(bus.err), 36'd1);
    issue(32'h0);
    issue(32'h0);
    check("ill_nowb", 36'(bus.wb_en), 36'd0);
    add(enc_i(7'h0A, 5'd11, 5'd0, 15'd3), 1, 5'd11, 36'd3);
    run_prog("after_ill");
    check("ill_sticky", 36'(bus.err), 36'd1);

    // Asynchronous reset between edges
    #1 rst = 1'b0;
    #1;
    check("arst_pc",    bus.pc,          36'd0);
    check("arst_err",   36'(bus.err),    36'd0);
    check("arst_wb_en", 36'(bus.wb_en),  36'd0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Reset flushes an in-flight ADDI r5,r0,9
    issue(enc_i(7'h0A, 5'd5, 5'd0, 15'd9));
    issue(32'h0);
    pulse_reset();
    add(enc_r(7'h03, 5'd6, 5'd5, 5'd0), 1, 5'd6, 36'd0);
    run_prog("flush");

    // Dependency chain: ADDI r1,r1,1 four times from r1=0
    pulse_reset();
    for (int k = 1; k <= 4; k++)
      add(enc_i(7'h0A, 5'd1, 5'd1, 15'd1), 1, 5'd1, 36'(k));
    run_prog("chain");

    // Randomized traffic against the model
    ins = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) pulse_reset();
      if ($urandom_range(0, 3) != 0) begin
        op = 7'($urandom_range(0, 11));
        if (op == 7'd11) op = 7'($urandom_range(11, 127));
        ins = $urandom;
        ins[31:25] = op;
        ins[24:20] = 5'($urandom_range(0, 7));
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[14:10] = 5'($urandom_range(0, 7));
      end
      issue(ins);
    end
    repeat (4) issue(32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
